// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sigma_mem_pkg
// Shared definitions for the core-memory arbiter:
//   - arbiter FSM state encoding (IDLE / ACCESS / DONE)
//   - requester IDs (REQ_CPU = 0, REQ_IO = 1)
//   - address bit range [15:31] and 32-bit word width (IBM-style MSB=0 numbering)
//   - wait-state counter width (WAIT_STATES legal range 0..15)
// ---------------------------------------------------------------------------
package sigma_mem_pkg;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 31;
  localparam int WORD_W   = 32;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_IO  = 1'b1
  } req_id_e;

  typedef logic [ADDR_MSB:ADDR_LSB] addr_t;
  typedef logic [0:WORD_W-1]        word_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the two requester handshakes (CPU, IOP) and the memory-array side
// of the arbiter.
//   modport slave  : the arbiter's view (requests and mem_data_in in,
//                    acks, read_data, memory strobes and owner out)
//   modport master : the environment's view (requesters plus memory array)
// ---------------------------------------------------------------------------
interface memory_arbiter_if;
  import sigma_mem_pkg::*;

  // CPU requester
  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_address;
  word_t cpu_data_out;
  logic  cpu_ack;

  // IOP DMA requester
  logic  io_req;
  logic  io_we;
  addr_t io_address;
  word_t io_data_out;
  logic  io_ack;

  // Shared read return
  word_t read_data;

  // Memory array side
  logic  mem_en;
  logic  mem_we;
  addr_t mem_address;
  word_t mem_data_out;
  word_t mem_data_in;

  // Currently granted requester (0 = CPU, 1 = IOP)
  logic  owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_address, cpu_data_out,
    input  io_req, io_we, io_address, io_data_out,
    input  mem_data_in,
    output cpu_ack, io_ack, read_data,
    output mem_en, mem_we, mem_address, mem_data_out,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_address, cpu_data_out,
    output io_req, io_we, io_address, io_data_out,
    output mem_data_in,
    input  cpu_ack, io_ack, read_data,
    input  mem_en, mem_we, mem_address, mem_data_out,
    input  owner
  );

endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the CPU and the IOP.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : on a tie the requester that was not granted last wins
//   undefined : fixed priority, the CPU always wins a tie
// Ports:
//   cpu_req_i      CPU request
//   io_req_i       IOP request
//   last_grant_i   requester granted most recently (used on ties only)
//   grant_valid_o  at least one request is pending
//   grant_id_o     selected requester
// ---------------------------------------------------------------------------
module mem_arb_pick
  import sigma_mem_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    io_req_i,
  input  req_id_e last_grant_i,
  output logic    grant_valid_o,
  output req_id_e grant_id_o
);

  always_comb begin
    grant_valid_o = cpu_req_i | io_req_i;
    grant_id_o    = REQ_CPU;
    if (cpu_req_i && io_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_id_o = (last_grant_i == REQ_CPU) ? REQ_IO : REQ_CPU;
`else
      grant_id_o = REQ_CPU;
`endif
    end else if (io_req_i) begin
      grant_id_o = REQ_IO;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Shares the single word-addressed core memory port between the CPU and the
// IOP DMA channel. One requester is granted at a time; each access runs
// WAIT_STATES+1 ACCESS cycles followed by a one-cycle acknowledge (DONE).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie breaking,
// implemented with a 1-bit last-grant register that resets to IOP so the
// first tie goes to the CPU).
// Parameters:
//   WAIT_STATES  extra memory cycles per access, 0..15
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   bus          memory_arbiter_if.slave (requesters + memory array)
// All outputs are registered.
// ---------------------------------------------------------------------------
module memory_arbiter
  import sigma_mem_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_id_e           owner_q;
  logic              mem_en_q;
  logic              mem_we_q;
  addr_t             mem_address_q;
  word_t             mem_data_out_q;
  word_t             read_data_q;
  logic              cpu_ack_q;
  logic              io_ack_q;

  logic              pick_valid;
  req_id_e           pick_id;
  req_id_e           last_grant;

  mem_arb_pick u_pick (
    .cpu_req_i     (bus.cpu_req),
    .io_req_i      (bus.io_req),
    .last_grant_i  (last_grant),
    .grant_valid_o (pick_valid),
    .grant_id_o    (pick_id)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Updated on every grant; reset to IOP so the first tie goes to the CPU.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_IO;
    end else if (state_q == ST_IDLE && pick_valid) begin
      last_grant <= pick_id;
    end
  end
`else
  assign last_grant = REQ_IO;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      owner_q        <= REQ_CPU;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      read_data_q    <= '0;
      cpu_ack_q      <= 1'b0;
      io_ack_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_q  <= pick_id;
            cnt_q    <= WAIT_CNT;
            mem_en_q <= 1'b1;
            if (pick_id == REQ_IO) begin
              mem_we_q       <= bus.io_we;
              mem_address_q  <= bus.io_address;
              mem_data_out_q <= bus.io_data_out;
            end else begin
              mem_we_q       <= bus.cpu_we;
              mem_address_q  <= bus.cpu_address;
              mem_data_out_q <= bus.cpu_data_out;
            end
            state_q <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (cnt_q == '0) begin
            // Last ACCESS cycle: memory data is valid now. mem_we_q still
            // holds the latched direction at this point.
            if (!mem_we_q) begin
              read_data_q <= bus.mem_data_in;
            end
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cpu_ack_q <= (owner_q == REQ_CPU);
            io_ack_q  <= (owner_q == REQ_IO);
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_DONE: begin
          cpu_ack_q <= 1'b0;
          io_ack_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.io_ack       = io_ack_q;
  assign bus.read_data    = read_data_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data_out = mem_data_out_q;
  assign bus.owner        = owner_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
// Self-checking bench for memory_arbiter: a table of single transactions on a
// WAIT_STATES=2 instance, plus hand-written sequences for continuous
// contention, WAIT_STATES=0, reset mid-access and request withdrawal.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int WS = 2;

  logic clock;
  logic reset;

  memory_arbiter_if bus ();
  memory_arbiter_if bus0 ();

  memory_arbiter #(.WAIT_STATES(WS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  memory_arbiter #(.WAIT_STATES(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        io_req;
    logic        io_we;
    logic [16:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] mem_rdata;
    logic        exp_owner;
    logic        exp_we;
    logic [16:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [16:0] ca, input logic [31:0] cd,
    input logic ir, input logic iw, input logic [16:0] ia, input logic [31:0] id,
    input logic [31:0] mr,
    input logic eo, input logic ew, input logic [16:0] ea, input logic [31:0] ed,
    input logic [31:0] er);
    vec_t v;
    v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
    v.io_req = ir;  v.io_we = iw;  v.io_addr = ia;  v.io_wdata = id;
    v.mem_rdata = mr;
    v.exp_owner = eo; v.exp_we = ew; v.exp_addr = ea; v.exp_wdata = ed;
    v.exp_rdata = er;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_address = '0; bus.cpu_data_out = '0;
    bus.io_req  = 1'b0; bus.io_we  = 1'b0; bus.io_address  = '0; bus.io_data_out  = '0;
    bus.mem_data_in = '0;
  endtask

  // Starts at a falling edge in IDLE; ends at a falling edge in IDLE.
  task automatic run_vec(input string tag, input vec_t v);
    bus.cpu_req = v.cpu_req; bus.cpu_we = v.cpu_we;
    bus.cpu_address = v.cpu_addr; bus.cpu_data_out = v.cpu_wdata;
    bus.io_req = v.io_req; bus.io_we = v.io_we;
    bus.io_address = v.io_addr; bus.io_data_out = v.io_wdata;
    bus.mem_data_in = v.mem_rdata;
    for (int k = 0; k <= WS; k++) begin
      @(negedge clock);
      chk($sformatf("%s acc%0d mem_en", tag, k), 32'(bus.mem_en), 32'd1);
      chk($sformatf("%s acc%0d mem_we", tag, k), 32'(bus.mem_we), 32'(v.exp_we));
      chk($sformatf("%s acc%0d mem_address", tag, k), 32'(bus.mem_address), 32'(v.exp_addr));
      chk($sformatf("%s acc%0d mem_data_out", tag, k), bus.mem_data_out, v.exp_wdata);
      chk($sformatf("%s acc%0d owner", tag, k), 32'(bus.owner), 32'(v.exp_owner));
      chk($sformatf("%s acc%0d acks", tag, k), 32'({bus.cpu_ack, bus.io_ack}), 32'd0);
    end
    @(negedge clock);
    chk($sformatf("%s done acks", tag), 32'({bus.cpu_ack, bus.io_ack}),
        v.exp_owner ? 32'd1 : 32'd2);
    chk($sformatf("%s done read_data", tag), bus.read_data, v.exp_rdata);
    chk($sformatf("%s done mem_en", tag), 32'({bus.mem_en, bus.mem_we}), 32'd0);
    bus.cpu_req = 1'b0;
    bus.io_req  = 1'b0;
    @(negedge clock);
    chk($sformatf("%s idle acks", tag), 32'({bus.cpu_ack, bus.io_ack}), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t v_after_reset;

  int   ack_time[$];
  logic ack_who[$];

  initial begin
    // -------- table: single transactions, WAIT_STATES = 2 --------
    vecs[0] = mk(1, 0, 17'h00010, 32'h0000_0000, 0, 0, 17'h00000, 32'h0,
                 32'hDEADBEEF, 0, 0, 17'h00010, 32'h0000_0000, 32'hDEADBEEF);
    vecs[1] = mk(0, 0, 17'h00000, 32'h0, 1, 1, 17'h1FFFF, 32'h12345678,
                 32'hFFFFFFFF, 1, 1, 17'h1FFFF, 32'h12345678, 32'hDEADBEEF);
    vecs[2] = mk(1, 1, 17'h0ABCD, 32'hA5A5A5A5, 0, 0, 17'h00000, 32'h0,
                 32'h0F0F0F0F, 0, 1, 17'h0ABCD, 32'hA5A5A5A5, 32'hDEADBEEF);
    vecs[3] = mk(0, 0, 17'h00000, 32'h0, 1, 0, 17'h00001, 32'h24681357,
                 32'hCAFEF00D, 1, 0, 17'h00001, 32'h24681357, 32'hCAFEF00D);
    // Tie: last grant was IOP, so the CPU wins in either build.
    vecs[4] = mk(1, 0, 17'h00100, 32'h13579BDF, 1, 1, 17'h00200, 32'h77777777,
                 32'h0BADF00D, 0, 0, 17'h00100, 32'h13579BDF, 32'h0BADF00D);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Tie again: last grant was CPU, so the IOP wins.
    vecs[5] = mk(1, 0, 17'h00300, 32'h55555555, 1, 0, 17'h00400, 32'h66666666,
                 32'h11223344, 1, 0, 17'h00400, 32'h66666666, 32'h11223344);
`else
    vecs[5] = mk(1, 0, 17'h00300, 32'h55555555, 1, 0, 17'h00400, 32'h66666666,
                 32'h11223344, 0, 0, 17'h00300, 32'h55555555, 32'h11223344);
`endif
    v_after_reset = mk(1, 0, 17'h00999, 32'h0, 0, 0, 17'h0, 32'h0,
                       32'h2468ACE0, 0, 0, 17'h00999, 32'h0, 32'h2468ACE0);

    // -------- reset state --------
    reset = 1'b1;
    idle_inputs();
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_address = '0; bus0.cpu_data_out = '0;
    bus0.io_req  = 1'b0; bus0.io_we  = 1'b0; bus0.io_address  = '0; bus0.io_data_out  = '0;
    bus0.mem_data_in = '0;
    repeat (3) @(negedge clock);
    chk("reset mem_en/we", 32'({bus.mem_en, bus.mem_we}), 32'd0);
    chk("reset acks", 32'({bus.cpu_ack, bus.io_ack}), 32'd0);
    chk("reset read_data", bus.read_data, 32'd0);
    chk("reset mem_address", 32'(bus.mem_address), 32'd0);
    chk("reset mem_data_out", bus.mem_data_out, 32'd0);
    chk("reset owner", 32'(bus.owner), 32'd0);
    chk("reset dut0 outputs", 32'({bus0.mem_en, bus0.cpu_ack, bus0.io_ack, bus0.owner}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post-reset idle mem_en", 32'(bus.mem_en), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // -------- continuous contention from a fresh reset --------
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 17'h00500;
    bus.io_req  = 1'b1; bus.io_we  = 1'b0; bus.io_address  = 17'h00600;
    bus.mem_data_in = 32'hABABABAB;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clock);
      if (bus.cpu_ack && bus.io_ack) begin
        chk($sformatf("contend both acks at %0d", n), 32'd1, 32'd0);
      end
      if (bus.cpu_ack || bus.io_ack) begin
        ack_time.push_back(n);
        ack_who.push_back(bus.io_ack);
      end
    end
    bus.cpu_req = 1'b0;
    bus.io_req  = 1'b0;
    chk("contend ack count", 32'(ack_time.size()), 32'd5);
    for (int j = 0; j < ack_time.size(); j++) begin
      chk($sformatf("contend ack%0d time", j), 32'(ack_time[j]), 32'(4 + 5 * j));
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("contend ack%0d who", j), 32'(ack_who[j]), 32'(j % 2));
`else
      chk($sformatf("contend ack%0d who", j), 32'(ack_who[j]), 32'd0);
`endif
    end
    @(negedge clock);
    @(negedge clock);
    chk("contend drained mem_en", 32'(bus.mem_en), 32'd0);

    // -------- WAIT_STATES = 0 instance --------
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_address = 17'h00042;
    bus0.mem_data_in = 32'h5A5A5A5A;
    @(negedge clock);
    chk("ws0 access mem_en", 32'(bus0.mem_en), 32'd1);
    chk("ws0 access ack", 32'(bus0.cpu_ack), 32'd0);
    chk("ws0 access mem_address", 32'(bus0.mem_address), 32'h00042);
    @(negedge clock);
    chk("ws0 done ack", 32'({bus0.cpu_ack, bus0.io_ack}), 32'd2);
    chk("ws0 done mem_en", 32'(bus0.mem_en), 32'd0);
    chk("ws0 done read_data", bus0.read_data, 32'h5A5A5A5A);
    bus0.cpu_req = 1'b0;
    @(negedge clock);
    chk("ws0 idle ack", 32'(bus0.cpu_ack), 32'd0);

    // -------- reset during the second ACCESS cycle of an IOP read --------
    idle_inputs();
    bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_address = 17'h00777;
    bus.mem_data_in = 32'h99999999;
    @(negedge clock);
    chk("rst-mid acc1 mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge clock);
    chk("rst-mid acc2 mem_en", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    bus.io_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("rst-mid mem_en/we", 32'({bus.mem_en, bus.mem_we}), 32'd0);
    chk("rst-mid acks", 32'({bus.cpu_ack, bus.io_ack}), 32'd0);
    chk("rst-mid read_data", bus.read_data, 32'd0);
    chk("rst-mid mem_address", 32'(bus.mem_address), 32'd0);
    chk("rst-mid owner", 32'(bus.owner), 32'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      chk($sformatf("rst-mid quiet%0d", n), 32'({bus.io_ack, bus.mem_en}), 32'd0);
    end
    run_vec("after-reset", v_after_reset);

    // -------- CPU withdraws req after one ACCESS cycle --------
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 17'h00ABC;
    bus.mem_data_in = 32'h13572468;
    @(negedge clock);
    chk("drop acc1 mem_en", 32'(bus.mem_en), 32'd1);
    bus.cpu_req = 1'b0;
    bus.cpu_address = 17'h1F000;
    @(negedge clock);
    chk("drop acc2 mem_address", 32'(bus.mem_address), 32'h00ABC);
    chk("drop acc2 mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge clock);
    chk("drop acc3 mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge clock);
    chk("drop done ack", 32'({bus.cpu_ack, bus.io_ack}), 32'd2);
    chk("drop done read_data", bus.read_data, 32'h13572468);
    @(negedge clock);
    chk("drop idle", 32'({bus.cpu_ack, bus.mem_en}), 32'd0);
    @(negedge clock);
    chk("drop no new access", 32'(bus.mem_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single word-addressed core memory port between the microcoded CPU and the I/O processor (IOP) DMA channel. The arbiter grants one requester at a time, sequences a fixed-length memory cycle with programmable wait states, and returns a one-cycle acknowledge with read data. It sits between the CPU's `memory_address` / `memory_data_in` path, the IOP, and the memory array.

## Interface
- `WAIT_STATES`, default 2: extra memory cycles per access; legal range 0..15.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_req` input 1: CPU requests an access; held until `cpu_ack`.
- `cpu_we` input 1: CPU access is a write.
- `cpu_address` input [15:31]: CPU word address.
- `cpu_data_out` input [0:31]: CPU write data.
- `cpu_ack` output 1: one-cycle completion strobe to CPU.
- `io_req`, `io_we`, `io_address[15:31]`, `io_data_out[0:31]`, `io_ack`: same as the CPU ports, for the IOP.
- `read_data` output [0:31]: read data register, shared by both requesters; valid only in the ack cycle.
- `mem_en` output 1: memory cycle active.
- `mem_we` output 1: memory write strobe.
- `mem_address` output [15:31]: latched access address.
- `mem_data_out` output [0:31]: latched write data.
- `mem_data_in` input [0:31]: memory read data, valid in the last ACCESS cycle.
- `owner` output 1: 0 = CPU, 1 = IOP; requester currently granted.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If either request is high, select a winner and latch its address, write data and `we` into the memory-side registers.
  - Load the wait counter with `WAIT_STATES`, set `owner` to the winner, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - `mem_en` = 1 throughout.
  - `mem_we` = latched `we` throughout.
  - The counter decrements each cycle.
  - When the counter is 0:
    - On a read, capture `mem_data_in` into `read_data`. On a write, leave `read_data` unchanged.
    - Go to DONE.
  - ACCESS therefore lasts `WAIT_STATES`+1 cycles.
- DONE:
  - Assert the owner's ack for exactly one cycle, then return to IDLE.
  - `mem_en` and `mem_we` are 0.
- A requester drops `req` on the clock edge that ends its ack cycle. A `req` still high in the following IDLE cycle is a new request.
- If `req` is withdrawn mid-access, the access still completes and the ack is still issued.
- Requester inputs are ignored outside IDLE. A changed address or data mid-access has no effect.
- Ack for the non-owner is always 0. `cpu_ack` and `io_ack` are never high together.
- Arbitration on a tie: CPU wins, unless `MEM_ARB_ROUND_ROBIN_EN` is defined (see Configuration).

## Timing
- Request sampled in IDLE at cycle N:
  - ACCESS runs cycles N+1 .. N+1+`WAIT_STATES`.
  - Ack is in cycle N+2+`WAIT_STATES`.
  - With the default of 2, ack is 4 cycles after the sampling cycle.
- Back-to-back accesses have one IDLE cycle between an ack and the next ACCESS. Throughput is one access per `WAIT_STATES`+3 cycles.
- Reset values: every output is 0, state is IDLE, counter is 0, the last-grant register is IOP.
- Reset asserted mid-access:
  - Next cycle is IDLE.
  - No ack is issued.
  - `mem_en` / `mem_we` drop immediately after the reset edge.
  - `read_data` is cleared.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant register is updated on every grant.
  - On a tie, the requester not granted last wins.
  - The first tie after reset goes to the CPU.
- Not defined:
  - Fixed priority: the CPU always wins ties.
  - No last-grant register is built.
  - The IOP can starve while the CPU requests continuously.

## Structure
- Shared package `sigma_mem_pkg`:
  - state encoding (IDLE / ACCESS / DONE);
  - requester IDs (`REQ_CPU` = 0, `REQ_IO` = 1);
  - address range constants (15, 31);
  - word width (32).
- One sub-module `mem_arb_pick`:
  - combinational winner selection from `cpu_req`, `io_req` and last-grant;
  - contains the only code affected by `MEM_ARB_ROUND_ROBIN_EN`.
- The FSM, counter and latches live in `memory_arbiter`.

## Test plan
- CPU read at address 0x00010, memory returns 0xDEADBEEF, `WAIT_STATES`=2 -> `mem_en` high 3 cycles, `cpu_ack` 4 cycles after sampling, `read_data`=0xDEADBEEF, `io_ack` stays 0.
- IOP write 0x12345678 to 0x1FFFF -> `mem_we`=1 for 3 cycles with `mem_address`=0x1FFFF, `mem_data_out`=0x12345678; `io_ack` one cycle; `owner`=1.
- Both requests high continuously:
  - Without the macro -> only `cpu_ack` pulses, every 5 cycles.
  - With the macro -> acks alternate CPU, IOP, CPU, IOP.
- `WAIT_STATES`=0 CPU read -> ACCESS lasts 1 cycle, ack 2 cycles after sampling.
- Reset pulsed during the second ACCESS cycle of an IOP read -> no `io_ack`, all outputs 0 next cycle; a fresh CPU request then completes normally.
- CPU `req` dropped after one ACCESS cycle -> access completes, `cpu_ack` still pulses; nothing is issued in the following IDLE cycle.
